// File: rtl/seq_commit_scheduler_if.sv
// Handshake bundle for seq_commit_scheduler.
//   alloc_*    : dispatch requests a sequence number (alloc_val/alloc_rdy),
//                granted number on alloc_seq_num.
//   complete_* : writeback reports a finished sequence number.
//   commit_*   : oldest instruction ready to retire (commit_val/commit_rdy),
//                commit_seq_num doubles as the ROB dequeue index.
//   in_flight  : allocated, not yet committed count.
// master = dispatch/writeback/retire side, slave = the scheduler.
interface seq_commit_scheduler_if #(
  parameter int unsigned p_seq_num_bits = 5
);
  logic                      alloc_val;
  logic                      alloc_rdy;
  logic [p_seq_num_bits-1:0] alloc_seq_num;
  logic                      complete_val;
  logic [p_seq_num_bits-1:0] complete_seq_num;
  logic                      commit_val;
  logic [p_seq_num_bits-1:0] commit_seq_num;
  logic                      commit_rdy;
  logic [p_seq_num_bits:0]   in_flight;

  modport master (
    output alloc_val,
    input  alloc_rdy,
    input  alloc_seq_num,
    output complete_val,
    output complete_seq_num,
    input  commit_val,
    input  commit_seq_num,
    output commit_rdy,
    input  in_flight
  );

  modport slave (
    input  alloc_val,
    output alloc_rdy,
    output alloc_seq_num,
    input  complete_val,
    input  complete_seq_num,
    output commit_val,
    output commit_seq_num,
    input  commit_rdy,
    output in_flight
  );
endinterface

// File: rtl/seq_commit_scheduler.sv
// In-order commit scheduler over a circular window of 2**p_seq_num_bits
// sequence numbers. Numbers are allocated at tail, marked done on writeback
// completion, and retired strictly in order from head.
// Ports:
//   clk : clock, all state updates on rising edge
//   rst : asynchronous active-low reset
//   bus : seq_commit_scheduler_if.slave (alloc / complete / commit handshakes,
//         in_flight count)
// All outputs are decoded from registered state only.
module seq_commit_scheduler #(
  parameter int unsigned p_seq_num_bits = 5
) (
  input logic                   clk,
  input logic                   rst,
  seq_commit_scheduler_if.slave bus
);

  localparam int unsigned depth_entries = 2 ** p_seq_num_bits;
  localparam logic [p_seq_num_bits:0] depth = {1'b1, {p_seq_num_bits{1'b0}}};

  logic [p_seq_num_bits-1:0] head;
  logic [p_seq_num_bits-1:0] tail;
  logic [p_seq_num_bits:0]   count;
  logic [depth_entries-1:0]  done;

  logic                      alloc_fire;
  logic                      commit_fire;
  logic                      complete_fire;
  logic [p_seq_num_bits-1:0] complete_offset;

  assign bus.alloc_rdy      = (count < depth);
  assign bus.alloc_seq_num  = tail;
  assign bus.commit_val     = (count != '0) && done[head];
  assign bus.commit_seq_num = head;
  assign bus.in_flight      = count;

  assign alloc_fire  = bus.alloc_val && bus.alloc_rdy;
  assign commit_fire = bus.commit_val && bus.commit_rdy;

  // Distance from head, modulo depth; in window iff below the live count.
  assign complete_offset = bus.complete_seq_num - head;
  assign complete_fire   = bus.complete_val && ({1'b0, complete_offset} < count);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      done  <= '0;
    end else begin
      // Set first, clears after: a completion of head in its own commit cycle
      // and any stale bit at a freshly allocated tail both end up cleared.
      if (complete_fire) done[bus.complete_seq_num] <= 1'b1;
      if (alloc_fire)    done[tail]                 <= 1'b0;
      if (commit_fire)   done[head]                 <= 1'b0;

      if (alloc_fire)  tail <= tail + p_seq_num_bits'(1);
      if (commit_fire) head <= head + p_seq_num_bits'(1);

      case ({alloc_fire, commit_fire})
        2'b10:   count <= count + (p_seq_num_bits + 1)'(1);
        2'b01:   count <= count - (p_seq_num_bits + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_commit_scheduler.sv
// Directed test of seq_commit_scheduler with p_seq_num_bits=2 (window of 4).
module tb_seq_commit_scheduler;

  localparam int unsigned nb = 2;

  logic clk;
  logic rst;
  int unsigned n_total;
  int unsigned n_bad;

  seq_commit_scheduler_if #(.p_seq_num_bits(nb)) bus ();

  seq_commit_scheduler #(.p_seq_num_bits(nb)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alloc_val        = 1'b0;
    bus.complete_val     = 1'b0;
    bus.complete_seq_num = '0;
    bus.commit_rdy       = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, ".alloc_rdy"},      32'(bus.alloc_rdy),      1);
    check_eq({tag, ".alloc_seq_num"},  32'(bus.alloc_seq_num),  0);
    check_eq({tag, ".commit_val"},     32'(bus.commit_val),     0);
    check_eq({tag, ".commit_seq_num"}, 32'(bus.commit_seq_num), 0);
    check_eq({tag, ".in_flight"},      32'(bus.in_flight),      0);
  endtask

  task automatic do_reset(input string tag);
    idle();
    rst = 1'b0;
    #1;
    check_reset_outputs(tag);
    step();
    rst = 1'b1;
  endtask

  task automatic alloc_n(input int unsigned n, input int unsigned first_seq, input string tag);
    for (int unsigned i = 0; i < n; i++) begin
      bus.alloc_val = 1'b1;
      check_eq({tag, ".alloc_seq"}, 32'(bus.alloc_seq_num), (first_seq + i) % 4);
      step();
    end
    bus.alloc_val = 1'b0;
  endtask

  task automatic complete_one(input int unsigned s);
    bus.complete_val     = 1'b1;
    bus.complete_seq_num = nb'(s);
    step();
    bus.complete_val     = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst     = 1'b1;
    idle();
    #2;

    // In-order commit after out-of-order completion.
    do_reset("rst0");
    alloc_n(3, 0, "t1");
    check_eq("t1.in_flight3", 32'(bus.in_flight), 3);
    bus.commit_rdy = 1'b1;
    complete_one(2);
    check_eq("t1.cv_after2", 32'(bus.commit_val), 0);
    complete_one(1);
    check_eq("t1.cv_after1", 32'(bus.commit_val), 0);
    complete_one(0);
    for (int unsigned i = 0; i < 3; i++) begin
      check_eq("t1.commit_val", 32'(bus.commit_val), 1);
      check_eq("t1.commit_seq", 32'(bus.commit_seq_num), i);
      step();
    end
    check_eq("t1.cv_end", 32'(bus.commit_val), 0);
    check_eq("t1.in_flight0", 32'(bus.in_flight), 0);
    idle();

    // Full window, commit while full, wrap of the tail.
    do_reset("rst1");
    alloc_n(4, 0, "t2");
    check_eq("t2.full_rdy", 32'(bus.alloc_rdy), 0);
    check_eq("t2.full_cnt", 32'(bus.in_flight), 4);
    complete_one(0);
    bus.commit_rdy = 1'b1;
    bus.alloc_val  = 1'b1;
    check_eq("t2.commit_val", 32'(bus.commit_val), 1);
    check_eq("t2.rdy_in_commit", 32'(bus.alloc_rdy), 0);
    step();
    bus.commit_rdy = 1'b0;
    check_eq("t2.cnt_after_commit", 32'(bus.in_flight), 3);
    check_eq("t2.rdy_after_commit", 32'(bus.alloc_rdy), 1);
    check_eq("t2.wrap_seq", 32'(bus.alloc_seq_num), 0);
    step();
    bus.alloc_val = 1'b0;
    check_eq("t2.cnt_refill", 32'(bus.in_flight), 4);
    check_eq("t2.tail_after_wrap", 32'(bus.alloc_seq_num), 1);
    idle();

    // Out-of-window completion is ignored.
    do_reset("rst2");
    alloc_n(1, 0, "t3");
    complete_one(3);
    alloc_n(3, 1, "t3b");
    complete_one(0);
    complete_one(1);
    complete_one(2);
    bus.commit_rdy = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      check_eq("t3.commit_seq", 32'(bus.commit_seq_num), i);
      step();
    end
    bus.commit_rdy = 1'b0;
    check_eq("t3.head3_seq", 32'(bus.commit_seq_num), 3);
    check_eq("t3.head3_not_done", 32'(bus.commit_val), 0);
    check_eq("t3.cnt1", 32'(bus.in_flight), 1);
    complete_one(3);
    check_eq("t3.head3_done", 32'(bus.commit_val), 1);
    bus.commit_rdy = 1'b1;
    step();
    bus.commit_rdy = 1'b0;
    check_eq("t3.cnt0", 32'(bus.in_flight), 0);
    idle();

    // Back-pressure hold, completion of head during its commit, stale bits.
    do_reset("rst3");
    alloc_n(2, 0, "t4");
    complete_one(0);
    for (int unsigned i = 0; i < 3; i++) begin
      check_eq("t4.hold_val", 32'(bus.commit_val), 1);
      check_eq("t4.hold_seq", 32'(bus.commit_seq_num), 0);
      step();
    end
    check_eq("t4.hold_cnt", 32'(bus.in_flight), 2);
    bus.commit_rdy       = 1'b1;
    bus.complete_val     = 1'b1;
    bus.complete_seq_num = nb'(0);
    step();
    idle();
    check_eq("t4.post_cnt", 32'(bus.in_flight), 1);
    check_eq("t4.post_seq", 32'(bus.commit_seq_num), 1);
    check_eq("t4.post_val", 32'(bus.commit_val), 0);
    alloc_n(3, 2, "t4b");
    complete_one(1);
    complete_one(2);
    complete_one(3);
    bus.commit_rdy = 1'b1;
    step();
    step();
    step();
    bus.commit_rdy = 1'b0;
    check_eq("t4.wrap_head", 32'(bus.commit_seq_num), 0);
    check_eq("t4.no_stale", 32'(bus.commit_val), 0);
    check_eq("t4.wrap_cnt", 32'(bus.in_flight), 1);
    idle();

    // Simultaneous alloc and commit, then reset mid-stream.
    do_reset("rst4");
    alloc_n(1, 0, "t5");
    complete_one(0);
    bus.commit_rdy = 1'b1;
    bus.alloc_val  = 1'b1;
    check_eq("t5.pre_cnt", 32'(bus.in_flight), 1);
    step();
    idle();
    check_eq("t5.both_cnt", 32'(bus.in_flight), 1);
    check_eq("t5.both_tail", 32'(bus.alloc_seq_num), 2);
    check_eq("t5.both_head", 32'(bus.commit_seq_num), 1);
    check_eq("t5.both_val", 32'(bus.commit_val), 0);
    alloc_n(1, 2, "t5b");
    complete_one(1);
    check_eq("t5.val_before_rst", 32'(bus.commit_val), 1);
    bus.commit_rdy = 1'b1;
    bus.alloc_val  = 1'b1;
    #3;
    rst = 1'b0;
    #1;
    check_reset_outputs("t5.async");
    step();
    check_reset_outputs("t5.held");
    rst = 1'b1;
    bus.commit_rdy = 1'b0;
    check_eq("t5.first_seq", 32'(bus.alloc_seq_num), 0);
    step();
    bus.alloc_val = 1'b0;
    check_eq("t5.first_cnt", 32'(bus.in_flight), 1);
    check_eq("t5.first_tail", 32'(bus.alloc_seq_num), 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
